// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, tx state encoding and a parity helper.
// The matching receiver uses this package too.
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_SB_TICK    = 16;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   // Even parity bit: set when the word holds an odd number of ones.
   function automatic logic even_parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-N s_tick counter: done marks the last tick of a bit period and the
// counter wraps to zero on it; load holds the counter at zero.
module uart_bit_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] term,
   output logic             done
);

   logic [CNT_W-1:0] count_r;

   assign done = (count_r == term);

   // tick counter, restarted by load or at the terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= {CNT_W{1'b0}};
      end else if (done) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one byte per accepted transmit_begin request.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int SB_TICK    = UART_SB_TICK
) (
   input  logic                 s_tick,
   input  logic                 rst_n,
   input  logic                 transmit_begin,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 tx,
   output logic                 transmit_active,
   output logic                 transmit_over
);

   localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int BIT_W    = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] OS_TERM  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SB_TERM  = CNT_W'(SB_TICK - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   tx_state_e            state_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic [BIT_W-1:0]     bit_cnt_r;
   logic                 tick_done_s;
   logic                 timer_load_s;
   logic [CNT_W-1:0]     timer_term_s;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
`endif

   // bit timer is parked in IDLE and uses the stop-bit length only in STOP
   always_comb begin
      timer_load_s = 1'b0;
      timer_term_s = OS_TERM;
      if (state_r == TX_IDLE) begin
         timer_load_s = 1'b1;
      end else begin
         timer_load_s = 1'b0;
      end
      if (state_r == TX_STOP) begin
         timer_term_s = SB_TERM;
      end else begin
         timer_term_s = OS_TERM;
      end
   end

   uart_bit_timer #(
      .CNT_W (CNT_W)
   ) u_bit_timer (
      .clk   (s_tick),
      .rst_n (rst_n),
      .load  (timer_load_s),
      .term  (timer_term_s),
      .done  (tick_done_s)
   );

   // frame FSM with shift register, bit counter and registered line/handshake outputs
   always_ff @(posedge s_tick or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= TX_IDLE;
         shreg_r         <= {DATA_BITS{1'b0}};
         bit_cnt_r       <= {BIT_W{1'b0}};
         tx              <= 1'b1;
         transmit_active <= 1'b0;
         transmit_over   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            TX_IDLE: begin
               if (transmit_begin) begin
                  shreg_r         <= data_in;
                  bit_cnt_r       <= {BIT_W{1'b0}};
                  tx              <= 1'b0;
                  transmit_active <= 1'b1;
                  transmit_over   <= 1'b0;
                  state_r         <= TX_START;
`ifdef UART_TX_PARITY_EN
                  parity_r        <= even_parity(32'(data_in));
`endif
               end
            end
            TX_START: begin
               if (tick_done_s) begin
                  bit_cnt_r <= {BIT_W{1'b0}};
                  tx        <= shreg_r[0];
                  state_r   <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tick_done_s) begin
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                     tx        <= parity_r;
                     state_r   <= TX_PARITY;
`else
                     tx        <= 1'b1;
                     state_r   <= TX_STOP;
`endif
                  end else begin
                     // the next bit is already sitting one place up
                     bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                     shreg_r   <= {1'b0, shreg_r[DATA_BITS-1:1]};
                     tx        <= shreg_r[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
               if (tick_done_s) begin
                  tx      <= 1'b1;
                  state_r <= TX_STOP;
               end
            end
`endif
            TX_STOP: begin
               if (tick_done_s) begin
                  tx              <= 1'b1;
                  transmit_active <= 1'b0;
                  transmit_over   <= 1'b1;
                  state_r         <= TX_IDLE;
               end
            end
            default: begin
               // unreachable encoding: park the line idle without claiming completion
               state_r         <= TX_IDLE;
               bit_cnt_r       <= {BIT_W{1'b0}};
               tx              <= 1'b1;
               transmit_active <= 1'b0;
               transmit_over   <= 1'b0;
            end
         endcase
      end
   end

endmodule
